// File: rtl/vote_pkg.sv
// Shared constants and types for the 3-voter ballot controller.
// Imported by the debouncer and the session FSM.
package vote_pkg;

    localparam int N_VOTERS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VOTE = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vote_session_ctrl_key_debounce.sv
// Key synchroniser plus stable-time debouncer.
// Emits a one-cycle pulse on each debounced press (1->0).
module key_debounce
    import vote_pkg::*;
#(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse
);

    localparam int DB_CYC = DEBOUNCE_MS * (CLK_FREQ / 1000);
    localparam int CW     = cw(DB_CYC);

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= 2'b11;
            stable      <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync        <= {sync[0], key_n};
            press_pulse <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYC - 1)) begin
                cnt         <= '0;
                stable      <= sync[1];
                press_pulse <= ~sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// Ballot sequencer: start key arms a timed vote window,
// then PASS/FAIL is shown for a fixed time.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int WINDOW_MS   = 10_000,
    parameter int SHOW_MS     = 3_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_start_n,
    input  logic [N_VOTERS-1:0] key_vote_n,
    output logic [N_VOTERS-1:0] led_voted_n,
    output logic                led_pass_n,
    output logic                led_fail_n,
    output logic                busy
);

    localparam int DIV   = CLK_FREQ / 1000;
    localparam int DW    = cw(DIV);
    localparam int MAXMS = (WINDOW_MS > SHOW_MS) ? WINDOW_MS : SHOW_MS;
    localparam int MW    = cw(MAXMS);

    logic [1:0] rst_q;
    logic       rst_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_q <= 2'b00;
        else        rst_q <= {rst_q[0], 1'b1};
    end

    assign rst_sync_n = rst_q[1];

    logic [DW-1:0] div_cnt;
    logic          tick;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DW'(DIV - 1)) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
            tick    <= 1'b0;
        end
    end

    logic                start_pulse;
    logic [N_VOTERS-1:0] vote_pulse;

    key_debounce #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_db_start (
        .clk         (clk),
        .rst_n       (rst_sync_n),
        .key_n       (key_start_n),
        .press_pulse (start_pulse)
    );

    for (genvar i = 0; i < N_VOTERS; i++) begin : g_vote
        key_debounce #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
            .clk         (clk),
            .rst_n       (rst_sync_n),
            .key_n       (key_vote_n[i]),
            .press_pulse (vote_pulse[i])
        );
    end

    state_t              state, state_nx;
    logic [N_VOTERS-1:0] voted, voted_nx;
    logic                pass, pass_nx;
    logic [MW-1:0]       win_cnt, win_nx;
    logic [MW-1:0]       show_cnt, show_nx;

    always_comb begin
        state_nx = state;
        voted_nx = voted;
        pass_nx  = pass;
        win_nx   = win_cnt;
        show_nx  = show_cnt;
        case (state)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_nx = ST_VOTE;
                    voted_nx = '0;
                    pass_nx  = 1'b0;
                    win_nx   = MW'(WINDOW_MS - 1);
                end
            end
            ST_VOTE: begin
                // a press landing on the expiry tick still counts
                voted_nx = voted | vote_pulse;
                if (tick && win_cnt != '0) win_nx = win_cnt - MW'(1);
                if ((&voted_nx) || (tick && win_cnt == '0)) begin
                    state_nx = ST_SHOW;
                    pass_nx  = (voted_nx[0] & voted_nx[1]) |
                               (voted_nx[1] & voted_nx[2]) |
                               (voted_nx[0] & voted_nx[2]);
                    show_nx  = MW'(SHOW_MS - 1);
                end
            end
            ST_SHOW: begin
                if (tick) begin
                    if (show_cnt == '0) begin
                        state_nx = ST_IDLE;
                        voted_nx = '0;
                        pass_nx  = 1'b0;
                    end else begin
                        show_nx = show_cnt - MW'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                voted_nx = '0;
                pass_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state       <= ST_IDLE;
            voted       <= '0;
            pass        <= 1'b0;
            win_cnt     <= '0;
            show_cnt    <= '0;
            led_voted_n <= '1;
            led_pass_n  <= 1'b1;
            led_fail_n  <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            voted       <= voted_nx;
            pass        <= pass_nx;
            win_cnt     <= win_nx;
            show_cnt    <= show_nx;
            led_voted_n <= ~voted_nx;
            led_pass_n  <= !((state_nx == ST_SHOW) && pass_nx);
            led_fail_n  <= !((state_nx == ST_SHOW) && !pass_nx);
            busy        <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: directed and random ballots
// checked against an event-level ballot model.
module tb_vote_session_ctrl;

    localparam int WIN = 50;
    localparam int SHW = 20;
    localparam int DB  = 2;
    // key edge to FSM update: 2 sync stages, DB stable cycles, pulse register
    localparam int LAT = 2 + DB + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_start_n;
    logic [2:0] key_vote_n;
    logic [2:0] led_voted_n;
    logic       led_pass_n;
    logic       led_fail_n;
    logic       busy;

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int t;
        int k;
        int len;
    } ev_t;

    ev_t evq[$];

    vote_session_ctrl #(
        .CLK_FREQ    (1000),
        .DEBOUNCE_MS (DB),
        .WINDOW_MS   (WIN),
        .SHOW_MS     (SHW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_start_n (key_start_n),
        .key_vote_n  (key_vote_n),
        .led_voted_n (led_voted_n),
        .led_pass_n  (led_pass_n),
        .led_fail_n  (led_fail_n),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int t, input int k, input int len);
        ev_t e;
        e.t = t;
        e.k = k;
        e.len = len;
        evq.push_back(e);
    endtask

    function automatic logic [3:0] keys_at(input int base, input int c);
        logic [3:0] lo;
        lo = '0;
        foreach (evq[i])
            if (c >= base + evq[i].t && c < base + evq[i].t + evq[i].len)
                lo[evq[i].k] = 1'b1;
        return lo;
    endfunction

    // Drive the queued key events for n cycles, no checking.
    task automatic play(input int n);
        int base;
        logic [3:0] lo;
        base = cyc;
        for (int c = base; c < base + n; c++) begin
            lo = keys_at(base, c);
            key_start_n = ~lo[3];
            key_vote_n  = ~lo[2:0];
            @(negedge clk);
        end
        key_start_n = 1'b1;
        key_vote_n  = '1;
        evq.delete();
    endtask

    // One full ballot: predict start, exit, outcome from the events,
    // then replay them and check the milestones.
    task automatic run_ballot();
        int base, e, x, stop;
        logic [2:0] set;
        logic [3:0] lo;
        logic ok;
        base = cyc;
        e = 1 << 30;
        foreach (evq[i])
            if (evq[i].k == 3 && evq[i].len >= DB && base + evq[i].t + LAT < e)
                e = base + evq[i].t + LAT;
        set = '0;
        x = e + WIN;
        for (int c = e + 1; c <= e + WIN; c++) begin
            foreach (evq[i])
                if (evq[i].k < 3 && evq[i].len >= DB &&
                    base + evq[i].t + LAT == c)
                    set[evq[i].k] = 1'b1;
            if (set == 3'b111) begin
                x = c;
                break;
            end
        end
        ok = ($countones(set) >= 2);
        stop = x + SHW + 2;
        foreach (evq[i])
            if (base + evq[i].t + evq[i].len + 4 > stop)
                stop = base + evq[i].t + evq[i].len + 4;
        for (int c = base; c <= stop; c++) begin
            if (c == e - 1) chk("busy_idle", {3'b0, busy}, 4'd0);
            if (c == e) begin
                chk("busy_vote", {3'b0, busy}, 4'd1);
                chk("voted_clr", {1'b0, led_voted_n}, 4'h7);
            end
            if (c == x - 1) begin
                chk("pass_pre", {3'b0, led_pass_n}, 4'd1);
                chk("fail_pre", {3'b0, led_fail_n}, 4'd1);
            end
            if (c == x) begin
                chk("pass_led", {3'b0, led_pass_n}, {3'b0, !ok});
                chk("fail_led", {3'b0, led_fail_n}, {3'b0, ok});
                chk("voted_led", {1'b0, led_voted_n}, {1'b0, ~set});
                chk("busy_show", {3'b0, busy}, 4'd1);
            end
            if (c == x + SHW - 1) begin
                chk("show_hold", {3'b0, busy}, 4'd1);
                chk("show_pass", {3'b0, led_pass_n}, {3'b0, !ok});
            end
            if (c == x + SHW) begin
                chk("busy_end", {3'b0, busy}, 4'd0);
                chk("pass_end", {3'b0, led_pass_n}, 4'd1);
                chk("fail_end", {3'b0, led_fail_n}, 4'd1);
                chk("voted_end", {1'b0, led_voted_n}, 4'h7);
            end
            if (c == stop) chk("idle_stay", {3'b0, busy}, 4'd0);
            lo = keys_at(base, c);
            key_start_n = ~lo[3];
            key_vote_n  = ~lo[2:0];
            @(negedge clk);
        end
        key_start_n = 1'b1;
        key_vote_n  = '1;
        evq.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s, t, n, len;
        rst_n       = 1'b0;
        key_start_n = 1'b1;
        key_vote_n  = '1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {3'b0, busy}, 4'd0);
        chk("rst_pass", {3'b0, led_pass_n}, 4'd1);
        chk("rst_fail", {3'b0, led_fail_n}, 4'd1);
        chk("rst_voted", {1'b0, led_voted_n}, 4'h7);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // a and b vote, window expires
        add(0, 3, 4); add(10, 0, 4); add(15, 1, 4);
        run_ballot();
        // c only, pressed three times
        add(0, 3, 4); add(10, 2, 4); add(20, 2, 4); add(30, 2, 4);
        run_ballot();
        // all three vote, early exit
        add(0, 3, 4); add(10, 0, 4); add(20, 1, 4); add(30, 2, 4);
        run_ballot();
        // one-cycle glitch on a is rejected
        add(0, 3, 4); add(10, 0, 1); add(20, 1, 5);
        run_ballot();
        // five-cycle press on a is accepted
        add(0, 3, 4); add(12, 0, 5);
        run_ballot();
        // b lands on the expiry tick; start during SHOW ignored
        add(0, 3, 4); add(10, 0, 4); add(WIN, 1, 4); add(60, 3, 4);
        run_ballot();

        for (int b = 0; b < 8; b++) begin
            s = $urandom_range(0, 8);
            add(s, 3, 4);
            for (int k = 0; k < 3; k++) begin
                t = $urandom_range(0, 6);
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) begin
                    len = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(3, 6);
                    add(t, k, len);
                    t = t + len + 6 + $urandom_range(0, 25);
                end
            end
            if ($urandom_range(0, 1) == 1) add(s + 12, 3, 4);
            run_ballot();
        end

        // reset mid-ballot with two votes in
        add(0, 3, 4); add(8, 0, 4); add(14, 1, 4);
        play(30);
        chk("mid_busy", {3'b0, busy}, 4'd1);
        chk("mid_voted", {1'b0, led_voted_n}, 4'h4);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {3'b0, busy}, 4'd0);
        chk("arst_voted", {1'b0, led_voted_n}, 4'h7);
        chk("arst_pass", {3'b0, led_pass_n}, 4'd1);
        chk("arst_fail", {3'b0, led_fail_n}, 4'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        add(0, 0, 5);
        play(20);
        chk("post_voted", {1'b0, led_voted_n}, 4'h7);
        chk("post_busy", {3'b0, busy}, 4'd0);
        add(0, 3, 4);
        play(10);
        chk("post_start", {3'b0, busy}, 4'd1);
        repeat (WIN + SHW + 5) @(negedge clk);
        chk("post_idle", {3'b0, busy}, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
